// File: rtl/gcd_unit_arbiter.sv
// rtl/gcd_unit_arbiter.sv - round-robin arbiter sharing one GCD unit between NREQ val/rdy requesters
// Define GCD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module gcd_unit_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_val,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*32-1:0]   req_msg,
  output logic [NREQ-1:0]      resp_val,
  input  logic [NREQ-1:0]      resp_rdy,
  output logic [15:0]          resp_msg,
  output logic                 gcd_req_val,
  input  logic                 gcd_req_rdy,
  output logic [31:0]          gcd_req_msg,
  input  logic                 gcd_resp_val,
  output logic                 gcd_resp_rdy,
  input  logic [15:0]          gcd_resp_msg
);
  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t          r_state;
  logic [OW-1:0]   r_owner;
  logic [31:0]     r_msg;
  logic [OW-1:0]   w_ptr;
  logic [OW-1:0]   w_grant;
  logic            w_any;
  logic [31:0]     w_sel_msg;
  logic            w_resp_fire;

`ifdef GCD_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [OW-1:0]   r_ptr;
  logic [OW-1:0]   w_ptr_next;
  assign w_ptr      = r_ptr;
  assign w_ptr_next = (r_owner == OW'(NREQ-1)) ? '0 : r_owner + 1'b1;
`endif

  // Scan from the farthest candidate back toward ptr so the nearest valid one wins.
  always_comb begin
    logic [OW:0] v_idx;
    w_grant = '0;
    w_any   = 1'b0;
    v_idx   = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      v_idx = {1'b0, w_ptr} + (OW+1)'(k);
      if (v_idx >= (OW+1)'(NREQ)) v_idx = v_idx - (OW+1)'(NREQ);
      if (req_val[v_idx[OW-1:0]]) begin
        w_grant = v_idx[OW-1:0];
        w_any   = 1'b1;
      end
    end
  end

  assign w_sel_msg   = req_msg[{w_grant, 5'b0} +: 32];
  assign w_resp_fire = (r_state == S_WAIT) && gcd_resp_val && resp_rdy[r_owner];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_msg   <= '0;
`ifndef GCD_ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_msg   <= w_sel_msg;
          r_owner <= w_grant;
          r_state <= S_SEND;
        end
        S_SEND: if (gcd_req_rdy) r_state <= S_WAIT;
        S_WAIT: if (w_resp_fire) begin
`ifndef GCD_ARB_FIXED_PRIO_EN
          r_ptr   <= w_ptr_next;
`endif
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are gated by reset so nothing fires while reset is held low.
  always_comb begin
    req_rdy  = '0;
    resp_val = '0;
    if (reset && (r_state == S_IDLE) && w_any) req_rdy[w_grant] = 1'b1;
    if (reset && (r_state == S_WAIT)) resp_val[r_owner] = gcd_resp_val;
  end

  assign gcd_req_val  = reset && (r_state == S_SEND);
  assign gcd_req_msg  = r_msg;
  assign gcd_resp_rdy = reset && (r_state == S_WAIT) && resp_rdy[r_owner];
  assign resp_msg     = gcd_resp_msg;

endmodule

// File: tb/tb_gcd_unit_arbiter.sv
// tb/tb_gcd_unit_arbiter.sv - self-checking bench for gcd_unit_arbiter (NREQ=2 and NREQ=3 instances)
module tb_gcd_unit_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_val, req_rdy, resp_val, resp_rdy;
  logic [63:0] req_msg;
  logic [15:0] resp_msg, gcd_resp_msg;
  logic        gcd_req_val, gcd_req_rdy, gcd_resp_val, gcd_resp_rdy;
  logic [31:0] gcd_req_msg;

  logic [2:0]  req_val3, req_rdy3, resp_val3, resp_rdy3;
  logic [95:0] req_msg3;
  logic [15:0] resp_msg3, gcd_resp_msg3;
  logic        gcd_req_val3, gcd_req_rdy3, gcd_resp_val3, gcd_resp_rdy3;
  logic [31:0] gcd_req_msg3;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;
  int m_ptr3   = 0;

  gcd_unit_arbiter #(.NREQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .gcd_req_val(gcd_req_val), .gcd_req_rdy(gcd_req_rdy), .gcd_req_msg(gcd_req_msg),
    .gcd_resp_val(gcd_resp_val), .gcd_resp_rdy(gcd_resp_rdy), .gcd_resp_msg(gcd_resp_msg)
  );

  gcd_unit_arbiter #(.NREQ(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_val(req_val3), .req_rdy(req_rdy3), .req_msg(req_msg3),
    .resp_val(resp_val3), .resp_rdy(resp_rdy3), .resp_msg(resp_msg3),
    .gcd_req_val(gcd_req_val3), .gcd_req_rdy(gcd_req_rdy3), .gcd_req_msg(gcd_req_msg3),
    .gcd_resp_val(gcd_resp_val3), .gcd_resp_rdy(gcd_resp_rdy3), .gcd_resp_msg(gcd_resp_msg3)
  );

  function automatic int gcd16(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Winner among the valid mask: nearest to ptr in wrapping order (lowest index if fixed priority).
  function automatic int exp_grant(input int ptr, input int val, input int n);
`ifdef GCD_ARB_FIXED_PRIO_EN
    ptr = 0;
`endif
    for (int k = 0; k < n; k++)
      if (((val >> ((ptr + k) % n)) & 1) != 0) return (ptr + k) % n;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Plays requesters and the GCD unit for one full transaction on the NREQ=2 instance.
  task automatic txn2(input logic [1:0] val, input logic [31:0] m0, input logic [31:0] m1,
                      input int send_stall, input int resp_stall,
                      output logic [1:0] rdy_o, output logic [31:0] gmsg_o,
                      output logic [1:0] rval_o, output logic [15:0] rmsg_o);
    req_val = val;
    req_msg = {m1, m0};
    @(negedge clk);
    rdy_o = req_rdy;
    tick;
    req_val = 2'b00;
    gcd_req_rdy = 1'b0;
    repeat (send_stall) tick;
    gcd_req_rdy = 1'b1;
    @(negedge clk);
    gmsg_o = gcd_req_msg;
    tick;
    gcd_req_rdy  = 1'b0;
    gcd_resp_val = 1'b1;
    gcd_resp_msg = 16'(gcd16(int'(gmsg_o[31:16]), int'(gmsg_o[15:0])));
    resp_rdy = 2'b00;
    repeat (resp_stall) tick;
    resp_rdy = 2'b11;
    @(negedge clk);
    rval_o = resp_val;
    rmsg_o = resp_msg;
    tick;
    gcd_resp_val = 1'b0;
    resp_rdy = 2'b00;
  endtask

  task automatic txn3(input logic [2:0] val, input logic [95:0] msgs,
                      output logic [2:0] rdy_o, output logic [2:0] rval_o, output logic [15:0] rmsg_o);
    logic [31:0] g;
    req_val3 = val;
    req_msg3 = msgs;
    @(negedge clk);
    rdy_o = req_rdy3;
    tick;
    req_val3 = 3'b000;
    gcd_req_rdy3 = 1'b1;
    @(negedge clk);
    g = gcd_req_msg3;
    tick;
    gcd_req_rdy3  = 1'b0;
    gcd_resp_val3 = 1'b1;
    gcd_resp_msg3 = 16'(gcd16(int'(g[31:16]), int'(g[15:0])));
    resp_rdy3 = 3'b111;
    @(negedge clk);
    rval_o = resp_val3;
    rmsg_o = resp_msg3;
    tick;
    gcd_resp_val3 = 1'b0;
    resp_rdy3 = 3'b000;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req_val = 2'b11; req_msg = {32'h1234_5678, 32'h9abc_def0};
    gcd_resp_val = 1'b1; resp_rdy = 2'b11;
    repeat (2) tick;
    @(negedge clk);
    checks++;
    if ({req_rdy, resp_val, gcd_req_val, gcd_resp_rdy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", {req_rdy, resp_val, gcd_req_val, gcd_resp_rdy});
    end
    checks++;
    if (gcd_req_msg !== 32'h0) begin
      failures++;
      $display("FAIL reset_msg_reg got=%h exp=00000000", gcd_req_msg);
    end
    req_val = 2'b00; gcd_resp_val = 1'b0; resp_rdy = 2'b00;
    tick;
    reset = 1'b1;
    m_ptr = 0;
    m_ptr3 = 0;
    tick;
  endtask

  task automatic test_single;
    logic [1:0] rdy, rval; logic [31:0] gm; logic [15:0] rm; int eg;
    txn2(2'b01, 32'h000F_0005, 32'h0, 0, 0, rdy, gm, rval, rm);
    checks++;
    if (rdy !== 2'b01) begin failures++; $display("FAIL single_rdy got=%b exp=01", rdy); end
    checks++;
    if (gm !== 32'h000F_0005) begin failures++; $display("FAIL single_gmsg got=%h exp=000f0005", gm); end
    checks++;
    if (rval !== 2'b01 || rm !== 16'h0005) begin
      failures++; $display("FAIL single_resp got=%b/%h exp=01/0005", rval, rm);
    end
    m_ptr = 1;
    eg = exp_grant(m_ptr, 3, 2);
    txn2(2'b11, 32'h0006_0004, 32'h0015_000E, 0, 0, rdy, gm, rval, rm);
    checks++;
    if (rdy !== 2'(1 << eg)) begin failures++; $display("FAIL ptr_after_single got=%b exp=%b", rdy, 2'(1 << eg)); end
    m_ptr = (eg + 1) % 2;
  endtask

  task automatic test_round_robin;
    logic [1:0] rdy, rval; logic [31:0] gm; logic [15:0] rm; int eg;
    for (int i = 0; i < 4; i++) begin
      eg = exp_grant(m_ptr, 3, 2);
      txn2(2'b11, 32'h001B_0009, 32'h0031_0007, 0, 0, rdy, gm, rval, rm);
      checks++;
      if (rdy !== 2'(1 << eg) || rval !== 2'(1 << eg) || rm !== ((eg == 0) ? 16'h0009 : 16'h0007)) begin
        failures++;
        $display("FAIL rr_%0d got rdy=%b rval=%b msg=%h exp grant=%0d", i, rdy, rval, rm, eg);
      end
      m_ptr = (eg + 1) % 2;
    end
  endtask

  task automatic test_send_stall;
    int eg; logic [31:0] m0, m1, em;
    m0 = $urandom; m1 = $urandom;
    eg = exp_grant(m_ptr, 3, 2);
    em = (eg == 0) ? m0 : m1;
    req_val = 2'b11; req_msg = {m1, m0};
    gcd_req_rdy = 1'b0;
    tick;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (gcd_req_val !== 1'b1 || gcd_req_msg !== em || req_rdy !== 2'b00) begin
        failures++;
        $display("FAIL send_stall_%0d got val=%b msg=%h rdy=%b exp 1/%h/00", c, gcd_req_val, gcd_req_msg, req_rdy, em);
      end
      tick;
    end
    gcd_req_rdy = 1'b1;
    tick;
    req_val = 2'b00; gcd_req_rdy = 1'b0;
    gcd_resp_val = 1'b1; gcd_resp_msg = 16'h0;
    resp_rdy = 2'b11;
    tick;
    gcd_resp_val = 1'b0; resp_rdy = 2'b00;
    m_ptr = (eg + 1) % 2;
  endtask

  task automatic test_resp_stall;
    req_val = 2'b10; req_msg = {32'h0024_0018, 32'h0};
    tick;
    req_val = 2'b00; gcd_req_rdy = 1'b1;
    tick;
    gcd_req_rdy = 1'b0;
    gcd_resp_val = 1'b1; gcd_resp_msg = 16'h000C;
    resp_rdy = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (gcd_resp_rdy !== 1'b0 || resp_val !== 2'b10) begin
        failures++;
        $display("FAIL resp_stall_%0d got rdy=%b val=%b exp 0/10", c, gcd_resp_rdy, resp_val);
      end
      tick;
    end
    resp_rdy = 2'b11;
    @(negedge clk);
    checks++;
    if (gcd_resp_rdy !== 1'b1 || resp_msg !== 16'h000C) begin
      failures++; $display("FAIL resp_release got rdy=%b msg=%h exp 1/000c", gcd_resp_rdy, resp_msg);
    end
    tick;
    resp_rdy = 2'b00;
    @(negedge clk);
    checks++;
    if (resp_val !== 2'b00 || gcd_req_val !== 1'b0) begin
      failures++; $display("FAIL resp_done_idle got val=%b greq=%b exp 00/0", resp_val, gcd_req_val);
    end
    gcd_resp_val = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset_mid;
    logic [1:0] rdy, rval; logic [31:0] gm; logic [15:0] rm; int eg;
    txn2(2'b01, 32'h0008_0004, 32'h0, 0, 0, rdy, gm, rval, rm);
    m_ptr = 1;
    req_val = 2'b01; req_msg = {32'h0, 32'h0009_0003};
    tick;
    req_val = 2'b00; gcd_req_rdy = 1'b1;
    tick;
    gcd_req_rdy = 1'b0; gcd_resp_val = 1'b1; gcd_resp_msg = 16'h0003; resp_rdy = 2'b00;
    @(negedge clk);
    checks++;
    if (resp_val !== 2'b01) begin failures++; $display("FAIL reset_mid_wait got=%b exp=01", resp_val); end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    resp_rdy = 2'b11;
    @(negedge clk);
    checks++;
    if ({req_rdy, resp_val, gcd_req_val, gcd_resp_rdy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_idle got=%b exp=000000", {req_rdy, resp_val, gcd_req_val, gcd_resp_rdy});
    end
    tick;
    gcd_resp_val = 1'b0; resp_rdy = 2'b00;
    m_ptr = 0;
    eg = exp_grant(m_ptr, 3, 2);
    txn2(2'b11, 32'h0, 32'h0, 0, 0, rdy, gm, rval, rm);
    checks++;
    if (rdy !== 2'(1 << eg) || rval !== 2'(1 << eg) || rm !== 16'h0000) begin
      failures++; $display("FAIL reset_mid_after got rdy=%b rval=%b msg=%h exp grant=%0d msg=0000", rdy, rval, rm, eg);
    end
    m_ptr = (eg + 1) % 2;
  endtask

  task automatic test_random;
    logic [1:0] rdy, rval, val; logic [31:0] gm, m0, m1, em; logic [15:0] rm; int eg, er;
    for (int i = 0; i < 20; i++) begin
      val = 2'($urandom_range(1, 3));
      m0 = $urandom; m1 = $urandom;
      eg = exp_grant(m_ptr, int'(val), 2);
      em = (eg == 0) ? m0 : m1;
      er = gcd16(int'(em[31:16]), int'(em[15:0]));
      txn2(val, m0, m1, $urandom_range(0, 2), $urandom_range(0, 2), rdy, gm, rval, rm);
      checks++;
      if (rdy !== 2'(1 << eg) || gm !== em || rval !== 2'(1 << eg) || rm !== 16'(er)) begin
        failures++;
        $display("FAIL random_%0d got rdy=%b gmsg=%h rval=%b msg=%h exp grant=%0d gmsg=%h msg=%h",
                 i, rdy, gm, rval, rm, eg, em, 16'(er));
      end
      m_ptr = (eg + 1) % 2;
    end
  endtask

  task automatic test_nreq3_wrap;
    logic [2:0] rdy, rval; logic [15:0] rm; logic [95:0] msgs; int eg, er;
    logic [2:0] seq [4];
    seq[0] = 3'b100; seq[1] = 3'b011; seq[2] = 3'b111; seq[3] = 3'b110;
    msgs = {32'h0030_0012, 32'h0019_000F, 32'h000E_0015};
    for (int i = 0; i < 4; i++) begin
      eg = exp_grant(m_ptr3, int'(seq[i]), 3);
      er = gcd16(int'(msgs[32*eg+16 +: 16]), int'(msgs[32*eg +: 16]));
      txn3(seq[i], msgs, rdy, rval, rm);
      checks++;
      if (rdy !== 3'(1 << eg) || rval !== 3'(1 << eg) || rm !== 16'(er)) begin
        failures++;
        $display("FAIL nreq3_%0d got rdy=%b rval=%b msg=%h exp grant=%0d msg=%h", i, rdy, rval, rm, eg, 16'(er));
      end
      m_ptr3 = (eg + 1) % 3;
    end
  endtask

  initial begin
    reset = 1'b0;
    req_val = '0; req_msg = '0; resp_rdy = '0;
    gcd_req_rdy = 1'b0; gcd_resp_val = 1'b0; gcd_resp_msg = '0;
    req_val3 = '0; req_msg3 = '0; resp_rdy3 = '0;
    gcd_req_rdy3 = 1'b0; gcd_resp_val3 = 1'b0; gcd_resp_msg3 = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_send_stall;
    test_resp_stall;
    test_reset_mid;
    test_random;
    test_nreq3_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
